rv32i_core: RTL and testbench

// - Single-cycle RV32I base-integer CPU core; top of the processor datapath.
// - Fetches from an external instruction memory and accesses an external data memory,

---
 rtl/rv32i_pkg.sv | 76 +++++++
 rtl/rv32i_alu.sv | 33 +++
 rtl/rv32i_core.sv | 220 ++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU ops and immediate formats.
// Also holds the immediate generator used by the core.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_t;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] i,
    input imm_t        t
  );
    logic [31:0] r;
    case (t)
      IMM_S: r = {{21{i[31]}}, i[30:25], i[11:7]};
      IMM_B: r = {{20{i[31]}}, i[7], i[30:25],
                  i[11:8], 1'b0};
      IMM_U: r = {i[31:12], 12'h000};
      IMM_J: r = {{12{i[31]}}, i[19:12], i[20],
                  i[30:21], 1'b0};
      default: r = {{21{i[31]}}, i[30:20]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit ALU for the single-cycle core.
// Shifts use only the low five bits of operand b.
import rv32i_pkg::*;

module rv32i_alu (
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [4:0] sh;
  assign sh = b[4:0];

  always_comb begin
    y = 32'h0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << sh;
      ALU_SLT:   y = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'h0, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> sh;
      ALU_SRA:   y = $signed(a) >>> sh;
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      default:   y = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: pc, regfile, decode,
// branch compare and load/store lane steering.
import rv32i_pkg::*;

module rv32i_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_addr,
  input  logic [31:0] data_rdata,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_we
);

  logic [31:0] pc;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        f7b;

  assign opcode = inst_rdata[6:0];
  assign rd     = inst_rdata[11:7];
  assign funct3 = inst_rdata[14:12];
  assign rs1    = inst_rdata[19:15];
  assign rs2    = inst_rdata[24:20];
  assign f7b    = inst_rdata[30];

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;

  assign is_lui   = opcode == OPC_LUI;
  assign is_auipc = opcode == OPC_AUIPC;
  assign is_jal   = opcode == OPC_JAL;
  assign is_jalr  = opcode == OPC_JALR;
  assign is_br    = opcode == OPC_BRANCH;
  assign is_ld    = opcode == OPC_LOAD;
  assign is_st    = opcode == OPC_STORE;
  assign is_opi   = opcode == OPC_OPIMM;
  assign is_op    = opcode == OPC_OP;

  alu_op_t alu_op;
  alu_op_t arith_op;
  imm_t    imm_sel;
  logic    a_pc;
  logic    b_imm;
  logic    wb_en;

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      F3_ADD:  arith_op = (is_op && f7b) ? ALU_SUB : ALU_ADD;
      F3_SLL:  arith_op = ALU_SLL;
      F3_SLT:  arith_op = ALU_SLT;
      F3_SLTU: arith_op = ALU_SLTU;
      F3_XOR:  arith_op = ALU_XOR;
      F3_SR:   arith_op = f7b ? ALU_SRA : ALU_SRL;
      F3_OR:   arith_op = ALU_OR;
      F3_AND:  arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = IMM_I;
    a_pc    = 1'b0;
    b_imm   = 1'b1;
    wb_en   = 1'b0;
    unique case (1'b1)
      is_lui: begin
        alu_op  = ALU_PASSB;
        imm_sel = IMM_U;
        wb_en   = 1'b1;
      end
      is_auipc: begin
        imm_sel = IMM_U;
        a_pc    = 1'b1;
        wb_en   = 1'b1;
      end
      is_jal: begin
        imm_sel = IMM_J;
        a_pc    = 1'b1;
        wb_en   = 1'b1;
      end
      is_jalr: wb_en = 1'b1;
      is_br: begin
        imm_sel = IMM_B;
        a_pc    = 1'b1;
      end
      is_ld: begin
        wb_en = (funct3 == F3_B) || (funct3 == F3_H)
             || (funct3 == F3_W) || (funct3 == F3_BU)
             || (funct3 == F3_HU);
      end
      is_st: imm_sel = IMM_S;
      is_opi: begin
        alu_op = arith_op;
        wb_en  = 1'b1;
      end
      is_op: begin
        alu_op = arith_op;
        b_imm  = 1'b0;
        wb_en  = 1'b1;
      end
      default: wb_en = 1'b0;
    endcase
  end

  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  assign imm   = imm_gen(inst_rdata, imm_sel);
  assign alu_a = a_pc ? pc : rs1_val;
  assign alu_b = b_imm ? imm : rs2_val;

  rv32i_alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  logic taken;

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = rs1_val == rs2_val;
      F3_BNE:  taken = rs1_val != rs2_val;
      F3_BLT:  taken = $signed(rs1_val) < $signed(rs2_val);
      F3_BGE:  taken = $signed(rs1_val) >= $signed(rs2_val);
      F3_BLTU: taken = rs1_val < rs2_val;
      F3_BGEU: taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal || (is_br && taken)) next_pc = alu_y;
    else if (is_jalr) next_pc = {alu_y[31:1], 1'b0};
  end

  // Load lanes come from the word containing data_addr.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign ld_byte = data_rdata[{alu_y[1:0], 3'b000} +: 8];
  assign ld_half = alu_y[1] ? data_rdata[31:16]
                            : data_rdata[15:0];

  always_comb begin
    case (funct3)
      F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_val = {24'h0, ld_byte};
      F3_HU:   ld_val = {16'h0, ld_half};
      default: ld_val = data_rdata;
    endcase
  end

  logic [3:0] st_we;

  always_comb begin
    st_we      = 4'b0000;
    data_wdata = rs2_val;
    case (funct3)
      F3_B: begin
        st_we      = 4'b0001 << alu_y[1:0];
        data_wdata = {4{rs2_val[7:0]}};
      end
      F3_H: begin
        st_we      = alu_y[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{rs2_val[15:0]}};
      end
      F3_W:    st_we = 4'b1111;
      default: st_we = 4'b0000;
    endcase
  end

  assign inst_addr = pc;
  assign data_addr = alu_y;
  assign data_we   = (is_st && !reset) ? st_we : 4'b0000;

  logic [31:0] wb_val;

  assign wb_val = is_ld               ? ld_val   :
                  (is_jal || is_jalr) ? pc_plus4 : alu_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Scoreboard bench for rv32i_core: drives one instruction
// per cycle and checks fetch address and data-port outputs.
module tb_rv32i_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_rdata;
  logic [31:0] inst_addr;
  logic [31:0] data_rdata;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;

  rv32i_core #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_rdata (inst_rdata),
    .inst_addr  (inst_addr),
    .data_rdata (data_rdata),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_we    (data_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic push(
    input string       tag,
    input int          fld,
    input logic [31:0] val
  );
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    sb.push_back(e);
  endtask

  // One cycle: drive inst, queue expectations, compare at negedge.
  task automatic cyc(
    input string       tag,
    input logic [31:0] inst,
    input logic [31:0] drd,
    input logic [31:0] e_pc,
    input logic [3:0]  e_we,
    input bit          ca,
    input logic [31:0] e_addr,
    input bit          cw,
    input logic [31:0] e_wd
  );
    exp_t        e;
    logic [31:0] got;
    inst_rdata = inst;
    data_rdata = drd;
    push({tag, ".pc"}, 0, e_pc);
    push({tag, ".we"}, 3, {28'h0, e_we});
    if (ca) push({tag, ".addr"}, 1, e_addr);
    if (cw) push({tag, ".wdata"}, 2, e_wd);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.fld)
        0:       got = inst_addr;
        1:       got = data_addr;
        2:       got = data_wdata;
        default: got = {28'h0, data_we};
      endcase
      check(e.tag, got, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    inst_rdata = 32'h0;
    data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", 32'h0, 0, 32'h0, 4'h0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc("addi", 32'h00500093, 0, 32'h00, 4'h0,
        1, 32'h5, 0, 0);
    cyc("sw", 32'h00102423, 0, 32'h04, 4'hF,
        1, 32'h8, 1, 32'h5);
    cyc("sb", 32'h001001A3, 0, 32'h08, 4'h8,
        1, 32'h3, 1, 32'h05050505);
    cyc("lb", 32'h00100103, 32'h00008000, 32'h0C, 4'h0,
        1, 32'h1, 0, 0);
    cyc("sw_lb", 32'h00202023, 0, 32'h10, 4'hF,
        1, 32'h0, 1, 32'hFFFFFF80);
    cyc("lbu", 32'h00104103, 32'h00008000, 32'h14, 4'h0,
        1, 32'h1, 0, 0);
    cyc("sw_lbu", 32'h00202023, 0, 32'h18, 4'hF,
        0, 0, 1, 32'h00000080);
    cyc("beq", 32'h00000463, 0, 32'h1C, 4'h0,
        0, 0, 0, 0);
    cyc("bne", 32'h00001463, 0, 32'h24, 4'h0,
        0, 0, 0, 0);
    cyc("jal", 32'h010000EF, 0, 32'h28, 4'h0,
        0, 0, 0, 0);
    cyc("sw_ra", 32'h00102023, 0, 32'h38, 4'hF,
        1, 32'h0, 1, 32'h2C);
    cyc("sh", 32'h00101123, 0, 32'h3C, 4'hC,
        1, 32'h2, 1, 32'h002C002C);
    cyc("addi_m1", 32'hFFF00193, 0, 32'h40, 4'h0,
        1, 32'hFFFFFFFF, 0, 0);
    cyc("lh", 32'h00201203, 32'h80010000, 32'h44, 4'h0,
        1, 32'h2, 0, 0);
    cyc("sw_lh", 32'h00402023, 0, 32'h48, 4'hF,
        0, 0, 1, 32'hFFFF8001);
    cyc("jalr", 32'h10100067, 0, 32'h4C, 4'h0,
        1, 32'h101, 0, 0);
    cyc("ecall", 32'h00000073, 0, 32'h100, 4'h0,
        0, 0, 0, 0);
    cyc("addi_x0", 32'h00700013, 0, 32'h104, 4'h0,
        0, 0, 0, 0);
    cyc("sw_x0", 32'h00002023, 0, 32'h108, 4'hF,
        0, 0, 1, 32'h0);
    cyc("sub", 32'h403082B3, 0, 32'h10C, 4'h0,
        1, 32'h2D, 0, 0);
    cyc("blt", 32'h0001C463, 0, 32'h110, 4'h0,
        0, 0, 0, 0);
    cyc("bltu", 32'h0001E463, 0, 32'h118, 4'h0,
        0, 0, 0, 0);
    cyc("end", 32'h00000013, 0, 32'h11C, 4'h0,
        0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
